// File: rtl/controle_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, FSM states,
// ALU operation codes, writeback source codes and the mux/type control bundle.
package controle_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] ULA_ADD = 2'b00;
  localparam logic [1:0] ULA_SUB = 2'b01;
  localparam logic [1:0] ULA_SLT = 2'b10;
  localparam logic [1:0] ULA_EQU = 2'b11;

  localparam logic [1:0] OPT_ULA = 2'b00;
  localparam logic [1:0] OPT_MEM = 2'b01;
  localparam logic [1:0] OPT_PC  = 2'b10;

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StMemory    = 3'd3,
    StWriteback = 3'd4,
    StHalt      = 3'd5,
    StError     = 3'd6
  } estado_e;

  typedef enum logic [3:0] {
    ClsR,
    ClsI,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsJal,
    ClsJalr,
    ClsAuipc,
    ClsEcall
  } classe_e;

  typedef struct packed {
    logic [1:0] op_ula;
    logic [1:0] operation_type;
    logic       ula_entry;
    logic       branch;
    logic       auipc;
    logic       jal;
    logic       jalr;
    logic       sign;
  } ctrl_t;

endpackage

// File: rtl/unidade_controle_multiciclo_if.sv
// Control bus between the multicycle control unit (master) and the datapath (slave).
interface unidade_controle_multiciclo_if;

  logic [31:0] instru;
  logic        load_en;
  logic        store_en;
  logic [1:0]  op_ula;
  logic [1:0]  operation_type;
  logic        ula_entry;
  logic        branch;
  logic        auipc;
  logic        jal;
  logic        jalr;
  logic        sign;
  logic        pc_en;
  logic        halted;
  logic        illegal_instr;
  logic [2:0]  estado;

  modport master (
    input  instru,
    output load_en, store_en, op_ula, operation_type, ula_entry, branch, auipc,
           jal, jalr, sign, pc_en, halted, illegal_instr, estado
  );

  modport slave (
    output instru,
    input  load_en, store_en, op_ula, operation_type, ula_entry, branch, auipc,
           jal, jalr, sign, pc_en, halted, illegal_instr, estado
  );

endinterface

// File: rtl/decodificador_instrucao.sv
// Combinational decode of the latched instruction into class, legality and
// the mux/type control bundle.
module decodificador_instrucao
  import controle_pkg::*;
(
  input  logic [31:0] i_ir,
  output classe_e     o_classe,
  output logic        o_legal,
  output ctrl_t       o_ctrl
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;

  assign w_opcode = i_ir[6:0];
  assign w_funct3 = i_ir[14:12];
  assign w_funct7 = i_ir[31:25];

  // Register and immediate fields are datapath business only.
  logic unused_ir;
  assign unused_ir = ^{i_ir[24:15], i_ir[11:7]};

  always_comb begin
    o_classe    = ClsR;
    o_legal     = 1'b1;
    o_ctrl      = '0;
    o_ctrl.sign = 1'b1;
    case (w_opcode)
      OP_R: begin
        o_classe         = ClsR;
        o_ctrl.ula_entry = 1'b1;
        if (w_funct7 != 7'b0000000 && w_funct7 != 7'b0100000) o_legal = 1'b0;
        case (w_funct3)
          3'b000:  o_ctrl.op_ula = w_funct7[5] ? ULA_SUB : ULA_ADD;
          3'b010:  o_ctrl.op_ula = ULA_SLT;
          3'b011: begin
            o_ctrl.op_ula = ULA_SLT;
            o_ctrl.sign   = 1'b0;
          end
          default: o_legal = 1'b0;
        endcase
      end
      OP_I: begin
        o_classe = ClsI;
        case (w_funct3)
          3'b000:  o_ctrl.op_ula = ULA_ADD;
          3'b010:  o_ctrl.op_ula = ULA_SLT;
          3'b011: begin
            o_ctrl.op_ula = ULA_SLT;
            o_ctrl.sign   = 1'b0;
          end
          default: o_legal = 1'b0;
        endcase
      end
      OP_LOAD: begin
        o_classe              = ClsLoad;
        o_ctrl.operation_type = OPT_MEM;
        o_legal               = (w_funct3 == 3'b011);
      end
      OP_STORE: begin
        o_classe = ClsStore;
        o_legal  = (w_funct3 == 3'b011);
      end
      OP_BRANCH: begin
        o_classe         = ClsBranch;
        o_ctrl.ula_entry = 1'b1;
        o_ctrl.branch    = 1'b1;
        case (w_funct3)
          3'b000, 3'b001: o_ctrl.op_ula = ULA_EQU;
          3'b100, 3'b101: o_ctrl.op_ula = ULA_SLT;
          3'b110, 3'b111: begin
            o_ctrl.op_ula = ULA_SLT;
            o_ctrl.sign   = 1'b0;
          end
          default: o_legal = 1'b0;
        endcase
      end
      OP_JAL: begin
        o_classe              = ClsJal;
        o_ctrl.jal            = 1'b1;
        o_ctrl.operation_type = OPT_PC;
      end
      OP_JALR: begin
        o_classe              = ClsJalr;
        o_ctrl.jalr           = 1'b1;
        o_ctrl.operation_type = OPT_PC;
        o_legal               = (w_funct3 == 3'b000);
      end
      OP_AUIPC: begin
        o_classe              = ClsAuipc;
        o_ctrl.auipc          = 1'b1;
        o_ctrl.operation_type = OPT_PC;
      end
      OP_SYSTEM: o_classe = ClsEcall;
      default:   o_legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control FSM: sequences each instruction through fetch/decode/
// execute/memory/writeback and pulses the datapath enables once per instruction.
module unidade_controle_multiciclo
  import controle_pkg::*;
#(
  parameter bit HALT_ON_ECALL = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  unidade_controle_multiciclo_if.master bus
);

  estado_e     r_estado;
  estado_e     w_estado_d;
  logic [31:0] r_ir;
  ctrl_t       r_ctrl;
  ctrl_t       w_ctrl_out;

  classe_e w_classe;
  logic    w_legal;
  ctrl_t   w_ctrl;

  logic w_load_en;
  logic w_store_en;
  logic w_pc_en;
  logic w_halted;
  logic w_illegal;

  decodificador_instrucao u_dec (
    .i_ir     (r_ir),
    .o_classe (w_classe),
    .o_legal  (w_legal),
    .o_ctrl   (w_ctrl)
  );

  always_comb begin
    w_estado_d = r_estado;
    w_load_en  = 1'b0;
    w_store_en = 1'b0;
    w_pc_en    = 1'b0;
    w_halted   = 1'b0;
    w_illegal  = 1'b0;
    case (r_estado)
      StFetch: w_estado_d = StDecode;
      StDecode: begin
        if (!w_legal)                 w_estado_d = StError;
        else if (w_classe == ClsEcall) w_estado_d = HALT_ON_ECALL ? StHalt : StError;
        else                          w_estado_d = StExecute;
      end
      StExecute: begin
        if (w_classe == ClsLoad || w_classe == ClsStore) begin
          w_estado_d = StMemory;
        end else if (w_classe == ClsBranch) begin
          w_pc_en    = 1'b1;
          w_estado_d = StFetch;
        end else begin
          w_estado_d = StWriteback;
        end
      end
      StMemory: begin
        if (w_classe == ClsStore) begin
          w_store_en = 1'b1;
          w_pc_en    = 1'b1;
          w_estado_d = StFetch;
        end else begin
          w_estado_d = StWriteback;
        end
      end
      StWriteback: begin
        w_load_en  = 1'b1;
        w_pc_en    = 1'b1;
        w_estado_d = StFetch;
      end
      StHalt:  w_halted  = 1'b1;
      StError: w_illegal = 1'b1;
      default: w_estado_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado <= StFetch;
      r_ir     <= '0;
      r_ctrl   <= '0;
    end else begin
      r_estado <= w_estado_d;
      if (r_estado == StFetch) r_ir <= bus.instru;
      // Bundle is loaded on entry to EXECUTE and dropped when the instruction retires.
      if (r_estado == StDecode && w_estado_d == StExecute) r_ctrl <= w_ctrl;
      else if (w_estado_d == StFetch)                      r_ctrl <= '0;
    end
  end

  // Reset forces every output low in the same cycle, even mid-instruction.
  assign w_ctrl_out = reset ? '0 : r_ctrl;

  assign bus.load_en        = w_load_en & ~reset;
  assign bus.store_en       = w_store_en & ~reset;
  assign bus.pc_en          = w_pc_en & ~reset;
  assign bus.halted         = w_halted & ~reset;
  assign bus.illegal_instr  = w_illegal & ~reset;
  assign bus.op_ula         = w_ctrl_out.op_ula;
  assign bus.operation_type = w_ctrl_out.operation_type;
  assign bus.ula_entry      = w_ctrl_out.ula_entry;
  assign bus.branch         = w_ctrl_out.branch;
  assign bus.auipc          = w_ctrl_out.auipc;
  assign bus.jal            = w_ctrl_out.jal;
  assign bus.jalr           = w_ctrl_out.jalr;
  assign bus.sign           = w_ctrl_out.sign;
  assign bus.estado         = r_estado;

endmodule
